// File: rtl/avalon_sdr_resp.sv
// rtl/avalon_sdr_resp.sv - Avalon-MM pipelined halfword memory responder with fixed read latency.
// Optional random backpressure: define AVALON_SDR_RESP_STALL_EN.
module avalon_sdr_resp #(
    parameter int          ADDR_BITS    = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 3,
    parameter int          MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_address,
    input  logic [15:0] avs_s0_writedata,
    input  logic [1:0]  avs_s0_byteenable,
    output logic        avs_s0_waitrequest,
    output logic [15:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    output logic        err,
    input  logic        err_clear,
    output logic [31:0] xfer_count
);
    localparam int         L        = READ_LATENCY;
    localparam logic [3:0] MAXP     = 4'(MAX_PENDING);
    localparam logic [15:0] BAD_DATA = 16'hDEAD;

    logic [15:0] mem_q [2**ADDR_BITS];

    logic [L-1:0] vld_q, vld_d;
    logic [15:0]  dat_q [L];
    logic [15:0]  dat_d [L];
    logic [3:0]   pending_q, pending_d;
    logic [31:0]  xfer_q, xfer_d;
    logic         err_q, err_d;

    logic [32:0]          diff;
    logic [31:0]          off;
    logic [ADDR_BITS-1:0] idx;
    logic                 addr_bad, both, rd_acc, wr_acc, retire, stall_term;

    // The borrow bit of the 33-bit subtract flags addresses below the base.
    assign diff     = {1'b0, avs_s0_address} - {1'b0, BASE_ADDR};
    assign off      = diff[31:0];
    assign idx      = off[ADDR_BITS:1];
    assign addr_bad = off[0] | diff[32] | (|off[31:ADDR_BITS+1]);

`ifdef AVALON_SDR_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign stall_term = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall_term = 1'b0;
`endif

    assign retire             = vld_q[L-1];
    assign avs_s0_waitrequest = reset | ((pending_q == MAXP) & ~retire) | stall_term;

    assign both   = avs_s0_read & avs_s0_write;
    assign rd_acc = avs_s0_read & ~avs_s0_write & ~avs_s0_waitrequest;
    assign wr_acc = avs_s0_write & ~avs_s0_read & ~avs_s0_waitrequest;

    // Each data stage only loads when a valid beat enters it, so the output holds between beats.
    always_comb begin
        vld_d = '0;
        dat_d = dat_q;
        vld_d[0] = rd_acc;
        if (rd_acc) dat_d[0] = addr_bad ? BAD_DATA : mem_q[idx];
        for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
        end

        case ({rd_acc, retire})
            2'b10:   pending_d = pending_q + 4'd1;
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase

        xfer_d = xfer_q + {31'd0, rd_acc | wr_acc};

        if (both | ((rd_acc | wr_acc) & addr_bad)) err_d = 1'b1;
        else if (err_clear)                        err_d = 1'b0;
        else                                       err_d = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            dat_q     <= '{default: '0};
            pending_q <= '0;
            xfer_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            pending_q <= pending_d;
            xfer_q    <= xfer_d;
            err_q     <= err_d;
        end
    end

    // Memory contents survive reset; bad writes are dropped here.
    always_ff @(posedge clk) begin
        if (wr_acc && !addr_bad) begin
            if (avs_s0_byteenable[0]) mem_q[idx][7:0]  <= avs_s0_writedata[7:0];
            if (avs_s0_byteenable[1]) mem_q[idx][15:8] <= avs_s0_writedata[15:8];
        end
    end

    assign avs_s0_readdata      = dat_q[L-1];
    assign avs_s0_readdatavalid = vld_q[L-1];
    assign err                  = err_q;
    assign xfer_count           = xfer_q;
endmodule

// File: tb/tb_avalon_sdr_resp.sv
// tb/tb_avalon_sdr_resp.sv - Directed scoreboard bench for avalon_sdr_resp.
module tb_avalon_sdr_resp;
    localparam int RL = 3;
    localparam int MP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, err_clear = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = 2'b11;
    logic        waitreq, rdv, err;
    logic [15:0] rdata;
    logic [31:0] xfer;

    int n_assert = 0, n_fail = 0;
    int cyc = 0;
    int exp_xfer = 0;
    int stalls = 0, burst_acc = 0, first_stall_acc = -1;
    logic [15:0] exp_d[$];
    int          exp_c[$];
    logic [15:0] rnd[64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_sdr_resp #(
        .ADDR_BITS(10), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(RL), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_s0_read(rd), .avs_s0_write(wr), .avs_s0_address(addr),
        .avs_s0_writedata(wdata), .avs_s0_byteenable(be),
        .avs_s0_waitrequest(waitreq), .avs_s0_readdata(rdata),
        .avs_s0_readdatavalid(rdv), .err(err), .err_clear(err_clear),
        .xfer_count(xfer)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rdv) begin
            if (exp_d.size() == 0) begin
                chk("spurious_rdv", 32'(rdv), 32'd0);
            end else begin
                automatic logic [15:0] d = exp_d.pop_front();
                automatic int          c = exp_c.pop_front();
                chk("rdata", 32'(rdata), 32'(d));
                chk("latency", 32'(cyc - c), 32'(RL - 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (waitreq && n < 100) begin
            stalls++;
            if (first_stall_acc < 0) first_stall_acc = burst_acc;
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("wait_timeout", 32'(waitreq), 32'd0);
    endtask

    task automatic issue_read(logic [31:0] a, logic [15:0] e);
        rd = 1'b1; wr = 1'b0; addr = a;
        wait_ready();
        tick();
        exp_d.push_back(e);
        exp_c.push_back(cyc);
        burst_acc++;
        exp_xfer++;
        chk("max_pending", 32'(exp_d.size() <= MP), 32'd1);
    endtask

    task automatic issue_write(logic [31:0] a, logic [15:0] d, logic [1:0] b);
        rd = 1'b0; wr = 1'b1; addr = a; wdata = d; be = b;
        wait_ready();
        tick();
        exp_xfer++;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (exp_d.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(exp_d.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_waitreq"}, 32'(waitreq), 32'd1);
        chk({tag, "_rdv"}, 32'(rdv), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_xfer"}, xfer, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
`ifndef AVALON_SDR_RESP_STALL_EN
        chk("waitreq_after_reset", 32'(waitreq), 32'd0);
`endif

        // Write then read, and readdata holding afterwards.
        issue_write(32'h0, 16'h1234, 2'b11);
        issue_read(32'h0, 16'h1234);
        drain();
        chk("err_clean", 32'(err), 32'd0);
        chk("xfer_two", xfer, 32'd2);
        repeat (4) tick();
        chk("rdata_hold", 32'(rdata), 32'h1234);
        chk("rdv_idle", 32'(rdv), 32'd0);

        // Byte enables, including the empty mask and the upper lane alone.
        issue_write(32'h4, 16'hAAAA, 2'b11);
        issue_write(32'h4, 16'h5555, 2'b01);
        issue_read(32'h4, 16'hAA55);
        issue_write(32'h4, 16'hFFFF, 2'b00);
        issue_read(32'h4, 16'hAA55);
        issue_write(32'h4, 16'h1200, 2'b10);
        issue_read(32'h4, 16'h1255);
        issue_write(32'h7FE, 16'hC0DE, 2'b11);
        issue_read(32'h7FE, 16'hC0DE);
        drain();
        chk("err_boundary", 32'(err), 32'd0);
        chk("xfer_mid", xfer, 32'(exp_xfer));

        // Back-to-back reads against the pending limit.
        for (int i = 0; i < 8; i++) issue_write(32'h10 + 32'(2 * i), 16'h0100 + 16'(i), 2'b11);
        burst_acc = 0;
        first_stall_acc = -1;
        for (int i = 0; i < 8; i++) issue_read(32'h10 + 32'(2 * i), 16'h0100 + 16'(i));
        drain();
`ifndef AVALON_SDR_RESP_STALL_EN
        chk("first_stall_after", 32'(first_stall_acc), 32'(MP));
`endif

        // Misaligned read, clear, and clear losing to a same-cycle set.
        issue_read(32'h3, 16'hDEAD);
        idle();
        chk("err_misaligned", 32'(err), 32'd1);
        drain();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        err_clear = 1'b1;
        issue_read(32'h3, 16'hDEAD);
        idle();
        chk("err_set_priority", 32'(err), 32'd1);
        tick();
        err_clear = 1'b0;
        chk("err_cleared2", 32'(err), 32'd0);
        drain();

        // Out-of-range write must not alias onto index 0.
        issue_write(32'h800, 16'hBEEF, 2'b11);
        idle();
        chk("err_oob_write", 32'(err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        issue_read(32'h0, 16'h1234);
        issue_read(32'h800, 16'hDEAD);
        drain();
        chk("err_oob_read", 32'(err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Read and write together: nothing accepted.
        rd = 1'b1; wr = 1'b1; addr = 32'h0; wdata = 16'hFFFF; be = 2'b11;
        tick();
        idle();
        chk("err_both", 32'(err), 32'd1);
        repeat (RL + 2) tick();
        chk("xfer_both", xfer, 32'(exp_xfer));
        issue_read(32'h0, 16'h1234);
        drain();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Reset one cycle after the last of three accepted reads.
        issue_read(32'h10, 16'h0100);
        issue_read(32'h12, 16'h0101);
        issue_read(32'h14, 16'h0102);
        idle();
        tick();
        reset = 1'b1;
        exp_d.delete();
        exp_c.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) tick();
        reset = 1'b0;
        exp_xfer = 0;
        repeat (10) tick();
        chk("rdv_after_reset", 32'(rdv), 32'd0);

        // 64 writes then 64 reads of random data.
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            rnd[i] = 16'($urandom);
            issue_write(32'h200 + 32'(2 * i), rnd[i], 2'b11);
        end
        for (int i = 0; i < 64; i++) issue_read(32'h200 + 32'(2 * i), rnd[i]);
        drain();
        chk("stall_seen", 32'(stalls > 0), 32'd1);
        chk("xfer_bulk", xfer, 32'd128);
        chk("err_bulk", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
